// File: rtl/u_rec.sv
// UART receiver: 8N1 deserialiser with a 16x bit-cell timebase, mid-cell sampling,
// one-cycle ready / framing-error strobes and break suppression.
module u_rec #(
    parameter int WORD_LEN = 8,
    parameter int BIT_CELL = 16
) (
    input  logic                sys_clk,
    input  logic                sys_rst_l,
    input  logic                uart_dataH,
    output logic [WORD_LEN-1:0] rec_dataH,
    output logic                rec_readyH,
    output logic                frame_errH,
    output logic                rec_busyH
);

    localparam int CW = $clog2(BIT_CELL);
    localparam int BW = $clog2(WORD_LEN + 1);
    localparam logic [CW-1:0] HALF_CELL = CW'(BIT_CELL / 2 - 1);
    localparam logic [CW-1:0] LAST_CELL = CW'(BIT_CELL - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(WORD_LEN - 1);

    typedef enum logic [2:0] {
        r_IDLE  = 3'd0,
        r_START = 3'd1,
        r_DATA  = 3'd2,
        r_STOP  = 3'd3,
        r_BREAK = 3'd4
    } state_t;

    state_t              state_reg, state_next;
    logic                s1_reg, s2_reg, s2_d_reg;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [BW-1:0]       bits_reg, bits_next;
    logic [WORD_LEN-1:0] shift_reg, shift_next;
    logic [WORD_LEN-1:0] data_reg, data_next;
    logic                ready_reg, ready_next;
    logic                err_reg, err_next;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_l) begin
            state_reg <= r_IDLE;
            s1_reg    <= 1'b1;
            s2_reg    <= 1'b1;
            s2_d_reg  <= 1'b1;
            cnt_reg   <= '0;
            bits_reg  <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            ready_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            s1_reg    <= uart_dataH;
            s2_reg    <= s1_reg;
            s2_d_reg  <= s2_reg;
            cnt_reg   <= cnt_next;
            bits_reg  <= bits_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            ready_reg <= ready_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bits_next  = bits_reg;
        shift_next = shift_reg;
        data_next  = data_reg;
        ready_next = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            r_IDLE: begin
                if (s2_d_reg && !s2_reg) begin
                    state_next = r_START;
                    cnt_next   = '0;
                end
            end
            r_START: begin
                cnt_next = cnt_reg + CW'(1);
                // Start bit must still be low at mid-cell, otherwise it was a glitch.
                if (cnt_reg == HALF_CELL) begin
                    if (!s2_reg) begin
                        state_next = r_DATA;
                        cnt_next   = '0;
                        bits_next  = '0;
                    end else begin
                        state_next = r_IDLE;
                    end
                end
            end
            r_DATA: begin
                cnt_next = cnt_reg + CW'(1);
                if (cnt_reg == LAST_CELL) begin
                    shift_next = {s2_reg, shift_reg[WORD_LEN-1:1]};
                    bits_next  = bits_reg + BW'(1);
                    cnt_next   = '0;
                    if (bits_reg == LAST_BIT) begin
                        state_next = r_STOP;
                    end
                end
            end
            r_STOP: begin
                cnt_next = cnt_reg + CW'(1);
                if (cnt_reg == LAST_CELL) begin
                    cnt_next = '0;
                    if (s2_reg) begin
                        data_next  = shift_reg;
                        ready_next = 1'b1;
                        state_next = r_IDLE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = r_BREAK;
                    end
                end
            end
            r_BREAK: begin
                // A held-low line must rise before another start edge is honoured.
                if (s2_reg) begin
                    state_next = r_IDLE;
                end
            end
            default: begin
                state_next = r_IDLE;
            end
        endcase
    end

    assign rec_dataH  = data_reg;
    assign rec_readyH = ready_reg;
    assign frame_errH = err_reg;
    assign rec_busyH  = (state_reg != r_IDLE) && (state_reg != r_BREAK);

endmodule

// File: doc/u_rec.md
# u_rec

UART receiver for the serial link driven by the team's UART transmitter (`u_xmit`). It takes the asynchronous serial line and a 16x bit-cell timebase in which one bit lasts 16 `sys_clk` cycles. It deserialises 8N1 frames (start bit, 8 data bits LSB first, one stop bit) and presents each byte with a one-cycle ready strobe and a framing-error strobe. It sits beside `u_xmit` in the UART top and shares its clock, reset and frame format.

## Interface
Parameters:
- `WORD_LEN`, 8: data bits per frame.
- `BIT_CELL`, 16: `sys_clk` cycles per bit; must be even and ≥ 4.

Ports:
- `sys_clk`  in  1  system clock; all logic on its rising edge.
- `sys_rst_l`  in  1  reset, synchronous and active-low.
- `uart_dataH`  in  1  serial line; idle high; asynchronous to `sys_clk`.
- `rec_dataH`  out  `WORD_LEN`  last good received byte; held until the next good frame.
- `rec_readyH`  out  1  one-cycle pulse; `rec_dataH` is valid and newly updated.
- `frame_errH`  out  1  one-cycle pulse; stop bit sampled low.
- `rec_busyH`  out  1  high while a frame is in progress (any state other than `r_IDLE` and `r_BREAK`).

## Operation
- Input conditioning: two-flop synchronizer `s1` → `s2`, plus `s2_d`, which is `s2` delayed one cycle. All decisions use `s2`.
- Bit-cell counter `cnt` is 4 bits wide for the default `BIT_CELL`; general width is `clog2(BIT_CELL)`. Bit counter `bits` runs 0..`WORD_LEN`.
- States:
  - `r_IDLE`: when `s2_d`=1 and `s2`=0 (falling edge), go to `r_START` and set `cnt`=0. Otherwise stay.
  - `r_START`: increment `cnt`.
    - At `cnt`==`BIT_CELL/2-1`, sample `s2`.
    - If `s2`=0: go to `r_DATA` with `cnt`=0 and `bits`=0.
    - If `s2`=1: this is a false start; return to `r_IDLE`. No strobe is generated.
  - `r_DATA`: increment `cnt`.
    - At `cnt`==`BIT_CELL-1`, shift `s2` into the MSB of the shift register (right shift, so bits land LSB first), increment `bits`, and wrap `cnt` to 0.
    - When `bits` reaches `WORD_LEN` on that sample, go to `r_STOP`.
  - `r_STOP`: increment `cnt`. At `cnt`==`BIT_CELL-1`, sample `s2`.
    - If `s2`=1: load `rec_dataH` from the shift register, pulse `rec_readyH`, go to `r_IDLE`.
    - If `s2`=0: pulse `frame_errH`, leave `rec_dataH` unchanged, go to `r_BREAK`.
  - `r_BREAK`: wait until `s2`=1, then go to `r_IDLE`. This prevents a held-low line (break) from being read as repeated frames.
- Unreachable state encodings return to `r_IDLE`.
- `rec_readyH` and `frame_errH` are never high in the same cycle.

## Timing
- Reset (`sys_rst_l`=0 at a rising edge) forces:
  - state `r_IDLE`;
  - `s1`, `s2`, `s2_d` = 1;
  - `cnt` = 0, `bits` = 0;
  - shift register = 0, `rec_dataH` = 0;
  - `rec_readyH`, `frame_errH`, `rec_busyH` = 0.
- Reset asserted mid-frame aborts the frame with no strobe. After release, a frame is accepted only after a fresh falling edge.
- Edge numbering: the line falls just before edge E0. With `BIT_CELL`=16:
  - `s2`=0 after E1, so the state enters `r_START` at E2.
  - Start-bit check at E10.
  - Data bit i is sampled at E26+16i.
  - Stop bit is sampled at E154; `rec_readyH` or `frame_errH` is high in the cycle following E154.
  - Every sample lands at mid-cell, ±1 cycle of synchronizer skew.
- The block is back in `r_IDLE` by E155. A back-to-back `u_xmit` frame (next falling edge at E160) is therefore received without loss.
- No backpressure. A consumer that misses the pulse loses the byte; `rec_dataH` is overwritten by the next good frame.
- Line glitches shorter than `BIT_CELL/2-2` cycles are rejected as false starts.

## Test plan
- Frame 0xA5 at 16 cycles/bit, line falling before E0 → `rec_readyH` one cycle after E154, `rec_dataH`=0xA5, `frame_errH` stays 0.
- Back-to-back frames 0x00 then 0xFF with no idle gap → two `rec_readyH` pulses 160 cycles apart, data 0x00 then 0xFF.
- 4-cycle low glitch on an idle line → no strobe, `rec_busyH` high for ≤ 9 cycles, return to `r_IDLE`.
- Frame 0x3C after a good 0x11, with stop bit driven 0 and held low for 40 cycles:
  - `frame_errH` pulses once;
  - `rec_dataH` stays 0x11;
  - no new frame starts until the line returns high and then falls again.
- `sys_rst_l` pulled low for 1 cycle during data bit 3 of 0x5A, followed by a fresh 0x96 frame:
  - the 0x5A frame produces no strobe, and all outputs read 0 the cycle after reset;
  - the 0x96 frame is received correctly.
- Frame generated by `u_xmit` with `xmit_dataH`=0xC3 looped into `uart_dataH` → `rec_dataH`=0xC3, one `rec_readyH` pulse.
